// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/execute bus for branch_resolve_unit (BRU_PERF_CNT_EN adds counters)
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_f;
  logic            pred_taken_f;
  logic            valid_e;
  logic            flush_e;
  logic [6:0]      opcode_e;
  logic [2:0]      funct3_e;
  logic [XLEN-1:0] rs1_e;
  logic [XLEN-1:0] rs2_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] target_e;
  logic            pred_taken_e;
  logic            br_taken_r;
  logic            mispredict_r;
  logic [XLEN-1:0] redirect_pc_r;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     br_count;
  logic [31:0]     mispredict_count;

  modport master (
    output pc_f, valid_e, flush_e, opcode_e, funct3_e, rs1_e, rs2_e, pc_e, target_e, pred_taken_e,
    input  pred_taken_f, br_taken_r, mispredict_r, redirect_pc_r, br_count, mispredict_count
  );
  modport slave (
    input  pc_f, valid_e, flush_e, opcode_e, funct3_e, rs1_e, rs2_e, pc_e, target_e, pred_taken_e,
    output pred_taken_f, br_taken_r, mispredict_r, redirect_pc_r, br_count, mispredict_count
  );
`else
  modport master (
    output pc_f, valid_e, flush_e, opcode_e, funct3_e, rs1_e, rs2_e, pc_e, target_e, pred_taken_e,
    input  pred_taken_f, br_taken_r, mispredict_r, redirect_pc_r
  );
  modport slave (
    input  pc_f, valid_e, flush_e, opcode_e, funct3_e, rs1_e, rs2_e, pc_e, target_e, pred_taken_e,
    output pred_taken_f, br_taken_r, mispredict_r, redirect_pc_r
  );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolve + bimodal BHT; BRU_PERF_CNT_EN adds branch/mispredict counters
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);
  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [XLEN:0]   diff;
  logic            zero;
  logic            neg;
  logic            ovf;
  logic            cond;
  logic            act;
  logic            is_br;
  logic            is_jmp;
  logic            taken;
  logic            unused_pc_bits;

  assign idx_f            = bus.pc_f[IDX_LSB +: IDX_W];
  assign idx_e            = bus.pc_e[IDX_LSB +: IDX_W];
  assign unused_pc_bits   = ^bus.pc_f;
  assign bus.pred_taken_f = bht[idx_f][1];

  // Extra top bit of diff is the unsigned borrow, i.e. rs1 < rs2 unsigned.
  assign diff = {1'b0, bus.rs1_e} - {1'b0, bus.rs2_e};
  assign zero = ~|diff[XLEN-1:0];
  assign neg  = diff[XLEN-1];
  assign ovf  = (bus.rs1_e[XLEN-1] ^ bus.rs2_e[XLEN-1]) & (diff[XLEN-1] ^ bus.rs1_e[XLEN-1]);

  always_comb begin
    cond = 1'b0;
    case (bus.funct3_e)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = neg ^ ovf;
      3'b101:  cond = ~(neg ^ ovf);
      3'b110:  cond = diff[XLEN];
      3'b111:  cond = ~diff[XLEN];
      default: cond = 1'b0;
    endcase
  end

  assign act    = bus.valid_e & ~bus.flush_e;
  assign is_br  = act & (bus.opcode_e == OP_BRANCH);
  assign is_jmp = act & ((bus.opcode_e == OP_JAL) | (bus.opcode_e == OP_JALR));
  assign taken  = is_jmp | (is_br & cond);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.br_taken_r    <= 1'b0;
      bus.mispredict_r  <= 1'b0;
      bus.redirect_pc_r <= '0;
    end else if (is_br | is_jmp) begin
      bus.br_taken_r    <= taken;
      bus.mispredict_r  <= is_jmp | (taken != bus.pred_taken_e);
      bus.redirect_pc_r <= taken ? bus.target_e : bus.pc_e + XLEN'(4);
    end else begin
      bus.br_taken_r    <= 1'b0;
      bus.mispredict_r  <= 1'b0;
      bus.redirect_pc_r <= '0;
    end
  end

  // Only conditional branches train; jumps are never predicted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (is_br) begin
      if (cond && bht[idx_e] != 2'b11)
        bht[idx_e] <= bht[idx_e] + 2'b01;
      else if (!cond && bht[idx_e] != 2'b00)
        bht[idx_e] <= bht[idx_e] - 2'b01;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.br_count         <= '0;
      bus.mispredict_count <= '0;
    end else if (is_br) begin
      bus.br_count <= bus.br_count + 32'd1;
      if (cond != bus.pred_taken_e) bus.mispredict_count <= bus.mispredict_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit (BRU_PERF_CNT_EN checks counters)
module tb_branch_resolve_unit;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  typedef struct {
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  logic [1:0] bht_m [64];

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .IDX_LSB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pred(input logic [31:0] pc, input string tag);
    bus.pc_f = pc;
    #1;
    check(tag, {31'd0, bus.pred_taken_f}, {31'd0, bht_m[pc[7:2]][1]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic flush, input logic exp_taken, input string tag);
    exp_t e;
    logic resolves;
    resolves = !flush && (op == OP_BR || op == OP_JAL || op == OP_JALR);
    e.tag    = tag;
    if (resolves) begin
      e.taken = exp_taken;
      e.mis   = (op == OP_BR) ? (exp_taken != pred) : 1'b1;
      e.redir = exp_taken ? tgt : pc + 32'd4;
    end else begin
      e.taken = 1'b0;
      e.mis   = 1'b0;
      e.redir = 32'd0;
    end
    sb.push_back(e);
    bus.valid_e = 1'b1; bus.flush_e = flush; bus.opcode_e = op; bus.funct3_e = f3;
    bus.rs1_e = a; bus.rs2_e = b; bus.pc_e = pc; bus.target_e = tgt; bus.pred_taken_e = pred;
    check_pred(pc, {tag, "_pred_pre"});
    @(posedge clk);
    #1;
    bus.valid_e = 1'b0;
    bus.flush_e = 1'b0;
    if (!flush && op == OP_BR) begin
      if (exp_taken && bht_m[pc[7:2]] != 2'b11) bht_m[pc[7:2]] = bht_m[pc[7:2]] + 2'b01;
      else if (!exp_taken && bht_m[pc[7:2]] != 2'b00) bht_m[pc[7:2]] = bht_m[pc[7:2]] - 2'b01;
    end
    e = sb.pop_front();
    check({e.tag, "_taken"}, {31'd0, bus.br_taken_r}, {31'd0, e.taken});
    check({e.tag, "_mis"}, {31'd0, bus.mispredict_r}, {31'd0, e.mis});
    check({e.tag, "_redir"}, bus.redirect_pc_r, e.redir);
    check_pred(pc, {tag, "_pred_post"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst = 1'b1;
    bus.pc_f = '0; bus.valid_e = 1'b0; bus.flush_e = 1'b0; bus.opcode_e = '0; bus.funct3_e = '0;
    bus.rs1_e = '0; bus.rs2_e = '0; bus.pc_e = '0; bus.target_e = '0; bus.pred_taken_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 64; i++) check_pred(32'(i) << 2, "reset_pred");
    check("reset_taken", {31'd0, bus.br_taken_r}, 32'd0);
    check("reset_mis", {31'd0, bus.mispredict_r}, 32'd0);
    check("reset_redir", bus.redirect_pc_r, 32'd0);

    issue(OP_BR, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h204, 32'h300, 1'b0, 1'b0, 1'b1, "blt_neg");
    issue(OP_BR, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h208, 32'h300, 1'b0, 1'b0, 1'b0, "bltu_big");
    issue(OP_BR, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h20C, 32'h300, 1'b1, 1'b0, 1'b0, "bge_neg");
    issue(OP_BR, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h210, 32'h300, 1'b1, 1'b0, 1'b1, "bgeu_big");
    issue(OP_BR, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h214, 32'h340, 1'b0, 1'b0, 1'b1, "blt_ovf");
    issue(OP_BR, 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 32'h218, 32'h340, 1'b0, 1'b0, 1'b1, "bge_ovf");
    issue(OP_BR, 3'b000, 32'h5, 32'h6, 32'h21C, 32'h340, 1'b0, 1'b0, 1'b0, "beq_ne");
    issue(OP_BR, 3'b010, 32'h5, 32'h5, 32'h220, 32'h340, 1'b0, 1'b0, 1'b0, "f3_010");

    for (int k = 0; k < 3; k++)
      issue(OP_BR, 3'b000, 32'h5, 32'h5, 32'h100, 32'h180, 1'b0, 1'b0, 1'b1, "train_beq");
    check("train_sat", {30'd0, bht_m[0]}, 32'd3);
    issue(OP_BR, 3'b001, 32'h5, 32'h5, 32'h100, 32'h180, 1'b0, 1'b0, 1'b0, "train_bne");
    check_pred(32'h100, "pred_after_bne");
    check("pred_after_bne_exp", {31'd0, bus.pred_taken_f}, 32'd1);

    issue(OP_BR, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b0, 1'b0, "seq_wrap");

    issue(OP_JALR, 3'b000, 32'h0, 32'h0, 32'h124, 32'h800, 1'b0, 1'b0, 1'b1, "jalr");
    issue(OP_JAL, 3'b000, 32'h0, 32'h0, 32'h128, 32'h900, 1'b1, 1'b0, 1'b1, "jal");
    issue(OP_JALR, 3'b000, 32'h0, 32'h0, 32'h124, 32'h800, 1'b0, 1'b1, 1'b1, "jalr_flush");
    issue(OP_BR, 3'b000, 32'h5, 32'h5, 32'h12C, 32'h800, 1'b0, 1'b1, 1'b1, "beq_flush");
    issue(OP_ALU, 3'b000, 32'h5, 32'h5, 32'h130, 32'h800, 1'b0, 1'b0, 1'b1, "alu_nop");

    issue(OP_BR, 3'b000, 32'h9, 32'h9, 32'h140, 32'h500, 1'b0, 1'b0, 1'b1, "pre_reset_mis");
    rst = 1'b1;
    #1;
    check("midrst_taken", {31'd0, bus.br_taken_r}, 32'd0);
    check("midrst_mis", {31'd0, bus.mispredict_r}, 32'd0);
    check("midrst_redir", bus.redirect_pc_r, 32'd0);
    model_reset();
    check_pred(32'h100, "midrst_pred_100");
    check_pred(32'h140, "midrst_pred_140");
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef BRU_PERF_CNT_EN
    check("perf_reset_br", bus.br_count, 32'd0);
    check("perf_reset_mis", bus.mispredict_count, 32'd0);
    for (int i = 0; i < 10; i++) begin
      logic tk;
      logic pr;
      tk = i[0];
      pr = (i < 4) ? ~tk : tk;
      issue(OP_BR, 3'b000, 32'h3, tk ? 32'h3 : 32'h4, 32'h400 + 32'(i * 4), 32'h600, pr, 1'b0, tk, "perf_br");
    end
    issue(OP_JAL, 3'b000, 32'h0, 32'h0, 32'h500, 32'h700, 1'b0, 1'b0, 1'b1, "perf_jal");
    check("perf_br_count", bus.br_count, 32'd10);
    check("perf_mis_count", bus.mispredict_count, 32'd4);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage branch resolution unit with an integrated bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch side: predicts direction for the fetch PC.
- Execute side: evaluates the RV32I branch condition at a parametrised operand width, trains the BHT, and emits a registered mispredict/redirect to the fetch and flush logic one cycle later.
- Successor to the purely combinational branch-condition block: adds prediction, training, redirect and optional statistics.

Parameters:
- XLEN, 32: operand and PC width.
- BHT_ENTRIES, 64: number of 2-bit counters; power of two, minimum 2.
- IDX_LSB, 2: lowest PC bit used for the BHT index. Index = pc[IDX_LSB +: log2(BHT_ENTRIES)].

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high. Clears all state.
- pc_f  in  XLEN  fetch PC for lookup.
- pred_taken_f  out  1  combinational prediction: counter[idx(pc_f)][1].
- valid_e  in  1  execute-stage instruction valid.
- flush_e  in  1  kill the execute instruction: no training, no outputs.
- opcode_e  in  7  execute-stage opcode.
- funct3_e  in  3  execute-stage funct3.
- rs1_e, rs2_e  in  XLEN  compare operands.
- pc_e  in  XLEN  PC of the execute instruction.
- target_e  in  XLEN  computed branch/jump target.
- pred_taken_e  in  1  prediction carried down the pipe from fetch.
- br_taken_r  out  1  registered actual outcome.
- mispredict_r  out  1  registered; fetch must redirect and flush younger instructions.
- redirect_pc_r  out  XLEN  registered correct next PC.

Behaviour:
- Reset (async, rst=1): every BHT counter = 2'b01 (weakly not-taken); br_taken_r, mispredict_r, redirect_pc_r = 0.
- Compare: diff = {1'b0,rs1_e} - {1'b0,rs2_e}, XLEN+1 bits. zero = ~|diff[XLEN-1:0]; neg = diff[XLEN-1]; ovf = signed-overflow of the subtraction.
  - BEQ 000: zero. BNE 001: ~zero.
  - BLT 100: neg^ovf. BGE 101: ~(neg^ovf).
  - BLTU 110: diff[XLEN]. BGEU 111: ~diff[XLEN].
  - funct3 010/011: not taken.
- Instruction class: act = valid_e & ~flush_e.
  - B-type (1100011): taken = condition above.
  - JAL (1101111), JALR (1100111): taken = 1.
  - Any other opcode: no-op.
- Registered outputs, 1-cycle latency. On each posedge, when act is true and the opcode is B/JAL/JALR:
  - br_taken_r <= taken.
  - redirect_pc_r <= taken ? target_e : pc_e + 4 (mod 2^XLEN).
  - B-type: mispredict_r <= (taken != pred_taken_e).
  - JAL/JALR: mispredict_r <= 1 always; fetch never predicts jumps.
  - Otherwise all three outputs <= 0. Mispredict is a single-cycle pulse per resolved instruction.
- BHT training: only when act is true and the opcode is B-type; jumps do not train.
  - Taken: counter += 1, saturating at 11.
  - Not taken: counter -= 1, saturating at 00.
- Simultaneous lookup and update of the same index: pred_taken_f returns the pre-update value. The write is visible the next cycle; no bypass.
- Aliasing: PCs sharing an index share a counter. This is intended.
- flush_e=1 with valid_e=1: behaves exactly as valid_e=0.
- Reset asserted mid-stream: state clears immediately, and any pending mispredict is lost.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined: adds two outputs, br_count 32 and mispredict_count 32.
  - br_count increments on every act B-type instruction.
  - mispredict_count increments on every act B-type mispredict; jumps are excluded.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: after reset, pred_taken_f=0 for all indices; all registered outputs are 0.
- Signed vs unsigned compare: rs1=0xFFFFFFFF, rs2=0x00000001.
  - BLT -> br_taken_r=1.
  - BLTU -> br_taken_r=0.
  - BGE -> 0. BGEU -> 1.
  - Also rs1=0x80000000, rs2=0x7FFFFFFF with BLT -> 1 (overflow case).
- Training:
  - Taken BEQ (rs1=rs2=5) at pc_e=0x100, issued 3 times with pred_taken_e=0.
  - mispredict_r sequence 1,1,1; redirect_pc_r=target_e each time.
  - pred_taken_f for pc_f=0x100 turns 1 after the first update; the counter saturates at 11.
  - Then 1 not-taken BNE at 0x100 leaves pred_taken_f=1 (counter 10).
- Sequential PC: not-taken BNE (rs1=rs2), pred_taken_e=0, pc_e=0xFFFFFFFC -> mispredict_r=0, redirect_pc_r=0x00000000 (wrap).
- Jumps and flush:
  - JALR with pred_taken_e=0 -> mispredict_r=1, br_taken_r=1, no BHT change.
  - Same instruction with flush_e=1 -> all outputs 0 and no counter change.
- Reset mid-stream and counters: assert rst in the cycle a mispredict is pending -> outputs 0 at once, counters back to 01.
  - With BRU_PERF_CNT_EN: 10 branches with 4 mispredicts -> br_count=10, mispredict_count=4.
